// File: rtl/axi_proxy_queue.sv
// axi_proxy_queue: AXI4-Lite command registers feeding a queued, sequence-numbered, marker-framed AXI-Stream link.
// Ports: clk, resetn (synchronous, active-low); AXIS_TDATA/TVALID/TREADY stream master;
//        S_AXI_* AXI4-Lite slave (ADDR 0x00, DATA 0x04, STATUS 0x08, SEQ 0x0C).
// Optional: define AXI_PROXY_AUTOINC_EN to post-increment ADDR by 4 after every accepted DATA write.
module axi_proxy_queue #(
  parameter int TDATA_W    = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               resetn,
  output logic [TDATA_W-1:0] AXIS_TDATA,
  output logic               AXIS_TVALID,
  input  logic               AXIS_TREADY,
  input  logic [31:0]        S_AXI_AWADDR,
  input  logic               S_AXI_AWVALID,
  output logic               S_AXI_AWREADY,
  input  logic [2:0]         S_AXI_AWPROT,
  input  logic [31:0]        S_AXI_WDATA,
  input  logic               S_AXI_WVALID,
  input  logic [3:0]         S_AXI_WSTRB,
  output logic               S_AXI_WREADY,
  output logic [1:0]         S_AXI_BRESP,
  output logic               S_AXI_BVALID,
  input  logic               S_AXI_BREADY,
  input  logic [31:0]        S_AXI_ARADDR,
  input  logic               S_AXI_ARVALID,
  input  logic [2:0]         S_AXI_ARPROT,
  output logic               S_AXI_ARREADY,
  output logic [31:0]        S_AXI_RDATA,
  output logic               S_AXI_RVALID,
  output logic [1:0]         S_AXI_RRESP,
  input  logic               S_AXI_RREADY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXI_PROXY_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  logic [95:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [31:0]        addr, last_data, seq, rd_val;
  logic [15:0]        drops;
  logic [4:0]         wr_idx, rd_idx;
  logic               wr_en, rd_en, data_wr, full, push, drop, load, pop;
  logic [TDATA_W-1:0] head_word;
  logic               unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_AWADDR[31:7], S_AXI_AWADDR[1:0],
                    S_AXI_ARADDR[31:7], S_AXI_ARADDR[1:0]};
  // Address and data are taken together; a new write waits until the previous response is consumed.
  assign wr_en         = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID;
  assign S_AXI_AWREADY = wr_en;
  assign S_AXI_WREADY  = wr_en;
  assign rd_en         = S_AXI_ARVALID && !S_AXI_RVALID;
  assign S_AXI_ARREADY = !S_AXI_RVALID;
  assign S_AXI_RRESP   = OKAY;
  assign wr_idx        = S_AXI_AWADDR[6:2];
  assign rd_idx        = S_AXI_ARADDR[6:2];
  assign data_wr       = wr_en && wr_idx == 5'd1;
  // Fullness uses this cycle's count only: a pop in the same cycle does not make room for the push.
  assign full          = count == CW'(FIFO_DEPTH);
  assign push          = data_wr && !full;
  assign drop          = data_wr && full;
  assign load          = !AXIS_TVALID || AXIS_TREADY;
  assign pop           = load && count != '0;
  assign rd_val        = rd_idx == 5'd0 ? addr :
                         rd_idx == 5'd1 ? last_data :
                         rd_idx == 5'd2 ? {drops, 16'(count)} :
                         rd_idx == 5'd3 ? seq : '0;
  // Only the 96-bit payload is queued; the frame markers are added as the word enters the output register.
  always_comb begin
    head_word = '0;
    head_word[95:0] = mem[rd_ptr];
    head_word[TDATA_W-1 -: 64] = 64'hBEADCAFE_FADEDBAD;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {seq, addr, S_AXI_WDATA};
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      AXIS_TVALID  <= 1'b0;
      AXIS_TDATA   <= '0;
      addr         <= '0;
      last_data    <= '0;
      seq          <= '0;
      drops        <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (load) AXIS_TVALID <= pop;
      if (pop) AXIS_TDATA <= head_word;
      if (wr_en && wr_idx == 5'd0) addr <= S_AXI_WDATA;
      else if (push && AUTOINC) addr <= addr + 32'd4;
      if (data_wr) last_data <= S_AXI_WDATA;
      if (push) seq <= seq + 32'd1;
      if (wr_en && wr_idx == 5'd2) drops <= '0;
      else if (drop && drops != 16'hFFFF) drops <= drops + 16'd1;
      if (wr_en) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= (wr_idx > 5'd3 || drop) ? SLVERR : OKAY;
      end else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      if (rd_en) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_val;
      end else if (S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_proxy_queue.sv
// tb_axi_proxy_queue: randomized scenarios against a queue-based model of the AXI-Lite to stream proxy.
module tb_axi_proxy_queue;
  localparam int TW = 512;
  localparam int DEPTH = 16;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXI_PROXY_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  logic clk, resetn;
  logic [TW-1:0] AXIS_TDATA;
  logic AXIS_TVALID, AXIS_TREADY;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BREADY;
  logic S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;
  logic [2:0] S_AXI_AWPROT, S_AXI_ARPROT;
  logic [3:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;

  axi_proxy_queue #(.TDATA_W(TW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID), .AXIS_TREADY(AXIS_TREADY),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RREADY(S_AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_strobe;
  logic [TW-1:0] rx[$];
  int rx_cyc[$];
  logic [TW-1:0] exp_q[$];
  logic [31:0] m_addr, m_last, m_seq;
  logic [15:0] m_drops;

  always @(negedge clk)
    if (resetn && AXIS_TVALID && AXIS_TREADY) begin
      rx.push_back(AXIS_TDATA);
      rx_cyc.push_back(cyc);
    end

  function automatic logic [TW-1:0] make_word(input logic [31:0] s, a, d);
    logic [TW-1:0] w;
    w = '0;
    w[31:0] = d;
    w[63:32] = a;
    w[95:64] = s;
    w[TW-1 -: 32] = 32'hBEADCAFE;
    w[TW-33 -: 32] = 32'hFADEDBAD;
    return w;
  endfunction

  function automatic int occupancy();
    return exp_q.size() - rx.size();
  endfunction

  // Words not yet delivered: one may sit in the output slot, so DEPTH+1 can be held in total.
  function automatic logic [1:0] model_write(input logic [31:0] a, d);
    int idx;
    idx = int'((a & 32'h7F) >> 2);
    if (idx == 0) begin
      m_addr = d;
      return OKAY;
    end
    if (idx == 1) begin
      m_last = d;
      if (occupancy() < DEPTH + 1) begin
        exp_q.push_back(make_word(m_seq, m_addr, d));
        m_seq = m_seq + 1;
        if (AUTOINC) m_addr = m_addr + 4;
        return OKAY;
      end
      if (m_drops != 16'hFFFF) m_drops = m_drops + 1;
      return SLVERR;
    end
    if (idx == 2) begin
      m_drops = 0;
      return OKAY;
    end
    return idx == 3 ? OKAY : SLVERR;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx, occ;
    idx = int'((a & 32'h7F) >> 2);
    occ = occupancy();
    if (idx == 0) return m_addr;
    if (idx == 1) return m_last;
    if (idx == 2) return {m_drops, 16'(occ > 0 ? occ - 1 : 0)};
    if (idx == 3) return m_seq;
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_addr = 0;
    m_last = 0;
    m_seq = 0;
    m_drops = 0;
    exp_q.delete();
    rx.delete();
    rx_cyc.delete();
  endtask

  task automatic axi_write(input logic [31:0] a, d, output logic [1:0] resp);
    int n;
    S_AXI_AWADDR = a;
    S_AXI_WDATA = d;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!S_AXI_AWREADY && n < 20);
    checks++;
    if (!S_AXI_AWREADY) begin
      failures++;
      $display("FAIL aw_handshake: awready=%b required 1 within 20 cycles", S_AXI_AWREADY);
    end
    last_strobe = cyc;
    @(posedge clk);
    #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
    if (n == 0) @(negedge clk);
    resp = S_AXI_BVALID ? S_AXI_BRESP : 2'bxx;
    @(posedge clk);
    #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    S_AXI_ARADDR = a;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!S_AXI_ARREADY && n < 20);
    @(posedge clk);
    #1;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!S_AXI_RVALID && n < 20);
    d = S_AXI_RVALID ? S_AXI_RDATA : 32'hxxxxxxxx;
    resp = S_AXI_RVALID ? S_AXI_RRESP : 2'bxx;
    @(posedge clk);
    #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, d, output logic [1:0] got, output logic [1:0] want);
    want = model_write(a, d);
    axi_write(a, d, got);
  endtask

  task automatic drain();
    int n;
    AXIS_TREADY = 1'b1;
    n = 0;
    while (rx.size() < exp_q.size() && n < 300) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0] r;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    checks++;
    if (AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b want 0", AXIS_TVALID); end
    checks++;
    if (AXIS_TDATA !== '0) begin failures++; $display("FAIL reset_tdata: got %h want 0", AXIS_TDATA); end
    for (int i = 0; i < 4; i++) begin
      axi_read(32'(i * 4), d, r);
      checks++;
      if (d !== model_read(32'(i * 4)) || r !== OKAY) begin
        failures++;
        $display("FAIL reset_reg%0d: got %h/%b want %h/%b", i, d, r, model_read(32'(i * 4)), OKAY);
      end
    end
  endtask

  task automatic test_single();
    logic [1:0] g, w;
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    AXIS_TREADY = 1'b1;
    do_write(32'h0, 32'h1000, g, w);
    checks++;
    if (g !== w) begin failures++; $display("FAIL single_addr_resp: got %b want %b", g, w); end
    do_write(32'h4, 32'hA5A5A5A5, g, w);
    lat = last_strobe;
    checks++;
    if (g !== w) begin failures++; $display("FAIL single_data_resp: got %b want %b", g, w); end
    drain();
    checks++;
    if (rx.size() != 1) begin failures++; $display("FAIL single_count: got %0d want 1", rx.size()); end
    checks++;
    if (rx.size() < 1 || rx[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL single_word: got %h want %h", rx.size() ? rx[0] : '0, exp_q[0]);
    end
    checks++;
    if (rx_cyc.size() < 1 || rx_cyc[0] != lat + 2) begin
      failures++;
      $display("FAIL single_latency: got cycle %0d want %0d", rx_cyc.size() ? rx_cyc[0] : -1, lat + 2);
    end
    axi_read(32'hC, d, r);
    checks++;
    if (d !== m_seq) begin failures++; $display("FAIL single_seq: got %h want %h", d, m_seq); end
    axi_read(32'h4, d, r);
    checks++;
    if (d !== m_last) begin failures++; $display("FAIL single_lastdata: got %h want %h", d, m_last); end
    exp_q.delete(); rx.delete(); rx_cyc.delete();
  endtask

  task automatic test_backpressure();
    logic [1:0] g, w, r;
    logic [31:0] d;
    logic [TW-1:0] held;
    AXIS_TREADY = 1'b0;
    do_write(32'h0, $urandom, g, w);
    held = '0;
    for (int i = 0; i < 16; i++) begin
      do_write(32'h4, $urandom, g, w);
      checks++;
      if (g !== w) begin failures++; $display("FAIL bp_resp%0d: got %b want %b", i, g, w); end
      if (i == 0) held = AXIS_TDATA;
    end
    checks++;
    if (AXIS_TVALID !== 1'b1) begin failures++; $display("FAIL bp_tvalid: got %b want 1", AXIS_TVALID); end
    checks++;
    if (AXIS_TDATA !== held || AXIS_TDATA !== exp_q[0]) begin
      failures++;
      $display("FAIL bp_stable: got %h want %h", AXIS_TDATA, exp_q[0]);
    end
    axi_read(32'h8, d, r);
    checks++;
    if (d !== model_read(32'h8)) begin failures++; $display("FAIL bp_status: got %h want %h", d, model_read(32'h8)); end
    drain();
    checks++;
    if (rx.size() != exp_q.size()) begin failures++; $display("FAIL bp_count: got %0d want %0d", rx.size(), exp_q.size()); end
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL bp_word%0d: got %h want %h", i, rx[i], exp_q[i]); end
      if (i > 0) begin
        checks++;
        if (rx_cyc[i] != rx_cyc[i-1] + 1) begin
          failures++;
          $display("FAIL bp_b2b%0d: got cycle %0d want %0d", i, rx_cyc[i], rx_cyc[i-1] + 1);
        end
      end
    end
    exp_q.delete(); rx.delete(); rx_cyc.delete();
  endtask

  task automatic test_overflow();
    logic [1:0] g, w, r;
    logic [31:0] d;
    int n_err;
    AXIS_TREADY = 1'b0;
    n_err = 0;
    for (int i = 0; i < 20; i++) begin
      do_write(32'h4, $urandom, g, w);
      if (g === SLVERR) n_err++;
      checks++;
      if (g !== w) begin failures++; $display("FAIL ovf_resp%0d: got %b want %b", i, g, w); end
    end
    checks++;
    if (n_err != 3) begin failures++; $display("FAIL ovf_slverr_count: got %0d want 3", n_err); end
    axi_read(32'h8, d, r);
    checks++;
    if (d !== model_read(32'h8)) begin failures++; $display("FAIL ovf_status: got %h want %h", d, model_read(32'h8)); end
    axi_read(32'hC, d, r);
    checks++;
    if (d !== m_seq) begin failures++; $display("FAIL ovf_seq: got %h want %h", d, m_seq); end
    do_write(32'h8, $urandom, g, w);
    checks++;
    if (g !== w) begin failures++; $display("FAIL ovf_clear_resp: got %b want %b", g, w); end
    axi_read(32'h8, d, r);
    checks++;
    if (d !== model_read(32'h8)) begin failures++; $display("FAIL ovf_cleared: got %h want %h", d, model_read(32'h8)); end
    drain();
    checks++;
    if (rx.size() != exp_q.size()) begin failures++; $display("FAIL ovf_count: got %0d want %0d", rx.size(), exp_q.size()); end
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_word%0d: got %h want %h", i, rx[i], exp_q[i]); end
    end
    exp_q.delete(); rx.delete(); rx_cyc.delete();
  endtask

  task automatic test_reset_mid();
    logic [1:0] g, w, r;
    logic [31:0] d;
    AXIS_TREADY = 1'b0;
    for (int i = 0; i < 5; i++) do_write(32'h4, $urandom, g, w);
    checks++;
    if (AXIS_TVALID !== 1'b1) begin failures++; $display("FAIL mid_pre_tvalid: got %b want 1", AXIS_TVALID); end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    checks++;
    if (AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL mid_tvalid: got %b want 0", AXIS_TVALID); end
    checks++;
    if (AXIS_TDATA !== '0) begin failures++; $display("FAIL mid_tdata: got %h want 0", AXIS_TDATA); end
    axi_read(32'h8, d, r);
    checks++;
    if (d !== model_read(32'h8)) begin failures++; $display("FAIL mid_status: got %h want %h", d, model_read(32'h8)); end
    axi_read(32'hC, d, r);
    checks++;
    if (d !== m_seq) begin failures++; $display("FAIL mid_seq: got %h want %h", d, m_seq); end
    AXIS_TREADY = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (rx.size() != 0) begin failures++; $display("FAIL mid_leftover: got %0d words want 0", rx.size()); end
  endtask

  task automatic test_bad_offset();
    logic [1:0] g, w, r;
    logic [31:0] d;
    do_write(32'h0, 32'h55, g, w);
    do_write(32'h10, $urandom, g, w);
    checks++;
    if (g !== w) begin failures++; $display("FAIL bad_wr_resp: got %b want %b", g, w); end
    axi_read(32'h10, d, r);
    checks++;
    if (d !== model_read(32'h10) || r !== OKAY) begin
      failures++;
      $display("FAIL bad_rd: got %h/%b want %h/%b", d, r, model_read(32'h10), OKAY);
    end
    axi_read(32'h0, d, r);
    checks++;
    if (d !== m_addr) begin failures++; $display("FAIL bad_no_effect: got %h want %h", d, m_addr); end
  endtask

  task automatic test_random();
    logic [1:0] g, w, r;
    logic [31:0] d;
    int n;
    for (int round = 0; round < 6; round++) begin
      do_write(32'h0, $urandom, g, w);
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        AXIS_TREADY = 1'($urandom_range(0, 1));
        do_write(32'h4, $urandom, g, w);
        checks++;
        if (g !== w) begin failures++; $display("FAIL rnd_resp%0d_%0d: got %b want %b", round, i, g, w); end
      end
      axi_read(32'hC, d, r);
      checks++;
      if (d !== m_seq) begin failures++; $display("FAIL rnd_seq%0d: got %h want %h", round, d, m_seq); end
      drain();
      checks++;
      if (rx.size() != exp_q.size()) begin failures++; $display("FAIL rnd_count%0d: got %0d want %0d", round, rx.size(), exp_q.size()); end
      for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
        checks++;
        if (rx[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_word%0d_%0d: got %h want %h", round, i, rx[i], exp_q[i]); end
      end
      exp_q.delete(); rx.delete(); rx_cyc.delete();
    end
  endtask

  task automatic test_autoinc();
    logic [1:0] g, w, r;
    logic [31:0] d;
    AXIS_TREADY = 1'b1;
    do_write(32'h0, 32'h100, g, w);
    for (int i = 0; i < 3; i++) do_write(32'h4, $urandom, g, w);
    drain();
    checks++;
    if (rx.size() != 3) begin failures++; $display("FAIL ainc_count: got %0d want 3", rx.size()); end
    for (int i = 0; i < rx.size() && i < 3; i++) begin
      checks++;
      if (rx[i][63:32] !== 32'h100 + (AUTOINC ? 32'(4 * i) : 32'h0) || rx[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ainc_word%0d: got %h want %h", i, rx[i], exp_q[i]);
      end
    end
    axi_read(32'h0, d, r);
    checks++;
    if (d !== m_addr) begin failures++; $display("FAIL ainc_addr: got %h want %h", d, m_addr); end
    exp_q.delete(); rx.delete(); rx_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    AXIS_TREADY = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_AWPROT = '0;
    S_AXI_WDATA = '0; S_AXI_WVALID = 1'b0; S_AXI_WSTRB = 4'hF;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_ARPROT = '0;
    S_AXI_RREADY = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_bad_offset();
    test_random();
    test_autoinc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_proxy_queue.md
Name:
axi_proxy_queue

Overview:
AXI4-Lite-to-AXI-Stream command proxy. Each software write to the DATA register becomes one queued, sequence-numbered, marker-framed stream word. Generalises the single-shot proxy: the stream width and queue depth are parameters, TREADY backpressure is honoured, and overflow is counted. It sits between the host AXI-Lite interconnect and the stream link to the remote ECD.

Parameters:
TDATA_W, 512, stream width in bits; multiple of 32, minimum 160
FIFO_DEPTH, 16, queued command entries; power of 2, range 2..256

Ports:
clk  input  1  clock
resetn  input  1  reset
AXIS_TDATA  output  TDATA_W  stream word
AXIS_TVALID  output  1  stream valid
AXIS_TREADY  input  1  stream ready
S_AXI_AWADDR  input  32  write address
S_AXI_AWVALID  input  1  AW valid
S_AXI_AWREADY  output  1  AW ready
S_AXI_AWPROT  input  3  ignored
S_AXI_WDATA  input  32  write data
S_AXI_WVALID  input  1  W valid
S_AXI_WSTRB  input  4  ignored; full-word writes only
S_AXI_WREADY  output  1  W ready
S_AXI_BRESP  output  2  write response
S_AXI_BVALID  output  1  B valid
S_AXI_BREADY  input  1  B ready
S_AXI_ARADDR  input  32  read address
S_AXI_ARVALID  input  1  AR valid
S_AXI_ARPROT  input  3  ignored
S_AXI_ARREADY  output  1  AR ready
S_AXI_RDATA  output  32  read data
S_AXI_RVALID  output  1  R valid
S_AXI_RRESP  output  2  read response
S_AXI_RREADY  input  1  R ready

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk. During reset, AXIS_TVALID=0, AXIS_TDATA=0, FIFO empty, ADDR=0, LASTDATA=0, SEQ=0, DROPS=0. A reset mid-transfer discards the queue and the output word.
- AXI-Lite handling uses the team's axi4_lite_slave core (ASHI handshake). Register decode is ((addr & 0x7F) >> 2).
- Register map:
  - 0x00 ADDR: read/write.
  - 0x04 DATA: write enqueues {SEQ, ADDR, wdata} and stores LASTDATA; read returns LASTDATA.
  - 0x08 STATUS: read returns [31:16] DROPS, [15:0] FIFO count; any write clears DROPS.
  - 0x0C SEQ: read-only; returns the next sequence number.
- Other offsets: writes return SLVERR with no side effect; reads return 0 with OKAY.
- Enqueue rules:
  - When the FIFO is not full: SEQ increments by 1 (32-bit, wraps 0xFFFFFFFF->0) and BRESP=OKAY.
  - When the FIFO is full: the write is dropped, SEQ is unchanged, DROPS increments (saturating at 0xFFFF), and BRESP=SLVERR.
  - Fullness is evaluated on the count in the cycle of the write. There is no bypass: simultaneous pop and push-on-full still drops.
- Output register:
  - Loaded from the FIFO head when TVALID=0 or (TVALID and TREADY).
  - TDATA and TVALID are held stable while TVALID and !TREADY.
  - Latency: a DATA write accepted on cycle N (ASHI write strobe) produces TVALID on N+2 when the queue and output are empty.
  - Sustained throughput is 1 word per cycle.
- Word layout:
  - [31:0] data
  - [63:32] addr
  - [95:64] seq
  - [TDATA_W-1:TDATA_W-32] 0xBEADCAFE
  - [TDATA_W-33:TDATA_W-64] 0xFADEDBAD
  - All other bits 0
- FIFO count ranges 0..FIFO_DEPTH. It excludes the output-register word.

Optional Feature:
AXI_PROXY_AUTOINC_EN
- Defined: each accepted (non-dropped) DATA write post-increments ADDR by 4, wrapping at 2^32. Dropped writes leave ADDR unchanged.
- Undefined: ADDR changes only via writes to 0x00.

Test Plan:
- Write ADDR=0x1000 then DATA=0xA5A5A5A5 with TREADY=1 -> one TVALID pulse 2 cycles later: [31:0]=0xA5A5A5A5, [63:32]=0x1000, [95:64]=0, top words BEADCAFE/FADEDBAD; SEQ reads 1.
- Hold TREADY=0 and write DATA 16 times -> STATUS[15:0]=15, TVALID=1 with TDATA stable; release TREADY -> 16 words in order, seq 0..15, back to back.
- With TREADY=0 and DEPTH=16, write DATA 20 times -> 3 SLVERR responses, STATUS[31:16]=3; write 0x08 -> DROPS=0.
- Assert resetn=0 for one cycle while 5 words are queued and TVALID=1 -> TVALID=0 next cycle, STATUS=0, SEQ=0.
- Write 0x10 -> BRESP=SLVERR; read 0x10 -> 0/OKAY; AUTOINC_EN build with ADDR=0x100 and 3 DATA writes -> addresses 0x100, 0x104, 0x108; ADDR reads 0x10C.
